keyboard_ctrl: RTL and testbench
================================

Name: keyboard_ctrl

Overview:
- PS/2 keyboard receiver feeding the memory-mapped keyboard vector and enable registers.
- Deserialises PS/2 frames and buffers scancodes in a FIFO.
- Raises a vectored interrupt request to the CPU: target is keyboardAddr, gated by keyboardEn.
- The CPU drains codes through a pop/read port that the memory decoder exposes as a status/data word.

Parameters:
- FIFO_DEPTH, 8, scancode FIFO entries; power of 2, minimum 2.
- FILTER_LEN, 4, consecutive identical samples needed before the filtered ps2Clk changes.
- TIMEOUT, 50000, clk cycles without a ps2Clk falling edge before a partial frame is abandoned.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low (rst=0 resets on the clk edge).
- ps2Clk  in  1  raw PS/2 clock, asynchronous.
- ps2Data  in  1  raw PS/2 data, asynchronous.
- en  in  1  interrupt enable; driven by keyboardEn.
- vecAddr  in  32  interrupt vector; driven by keyboardAddr.
- intReq  out  1  interrupt request, level.
- intAddr  out  32  vector latched when intReq rises.
- intAck  in  1  CPU acknowledge pulse.
- pop  in  1  remove FIFO head.
- errClr  in  1  clear sticky error flags.
- rdData  out  16  {valid, overflow, parityErr, frameErr, 4'b0, code[7:0]}.

Behaviour:
- Input conditioning:
  - ps2Clk and ps2Data each pass through a 2-FF synchroniser.
  - The filtered clock changes only after FILTER_LEN equal synchronised samples.
  - A falling edge of the filtered clock produces a 1-cycle sample strobe; ps2Data (synchronised) is sampled on that strobe.
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on strobe with data=0 (start bit), go to DATA with bitCnt=0. Data=1 is ignored.
  - DATA: shift in LSB first. After the 8th bit, go to PARITY.
  - PARITY: record the bit and go to STOP.
  - STOP:
    - If the stop bit is 1 and odd parity holds over data+parity, push the code.
    - If parity is wrong: set parityErr and discard the byte.
    - If the stop bit is 0: set frameErr and discard the byte.
    - Always return to IDLE.
- Timeout:
  - A counter reloads on every strobe and counts only while not in IDLE.
  - On reaching TIMEOUT: return to IDLE, set frameErr, discard the partial byte.
- FIFO:
  - Push occurs in the cycle after the STOP strobe.
  - Push when full: byte dropped, overflow set.
  - Simultaneous push and pop when full: both happen, count unchanged, no overflow.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH. The count is one bit wider than the pointers.
- rdData:
  - Combinational from the FIFO head.
  - valid=1 iff not empty. When empty, the code field is 0x00.
  - Error bits always reflect the sticky flags.
- Error flags:
  - Sticky; cleared by errClr.
  - errClr coincident with a new error in the same cycle: the error wins (flag stays set).
- Interrupt:
  - Rising: when intReq=0, en=1, FIFO not empty, and no ack this cycle, then intReq<=1 and intAddr<=vecAddr.
  - Holding: intReq stays 1 until intAck=1, then clears on the next edge.
  - Re-arm: no re-assert in the cycle right after the clear; it may re-assert the following cycle if the condition still holds.
  - en dropping while intReq=1 does not withdraw the request.
  - vecAddr changes do not affect an already latched intAddr.
- Reset values: intReq=0, intAddr=0, FIFO empty, all flags 0, FSM=IDLE, filtered clock=1, rdData=0x0000.
- Reset mid-frame discards the partial byte.

Decomposition:
- Shared package: state encoding (IDLE/DATA/PARITY/STOP), rdData bit positions (VALID_BIT=15, OVF_BIT=14, PAR_BIT=13, FRM_BIT=12), default TIMEOUT.
- One sub-module is natural: kbd_fifo, a synchronous FIFO with push/pop/full/empty and the head output.

Test Plan:
- Send a valid frame for 0x1C (start 0, data LSB-first, parity 0, stop 1) with en=1 and vecAddr=0x00001234.
  - rdData=0x801C.
  - intReq rises with intAddr=0x00001234.
  - intAck pulse drops intReq; pop gives rdData=0x0000.
- Frame 0x1C with parity 1.
  - rdData=0x2000 (parityErr only, no valid).
  - intReq stays 0.
  - errClr then gives rdData=0x0000.
- Send 9 valid frames 0x01..0x09 with FIFO_DEPTH=8, no pop.
  - rdData=0xC001.
  - After 8 pops, codes 0x01..0x08 have been read in order and the FIFO is empty.
- Drop ps2Clk activity after 4 data bits and wait TIMEOUT+2 cycles.
  - frameErr set, FSM back in IDLE.
  - Next valid frame 0xF0 yields rdData=0x90F0.
- Glitch: a 2-cycle low pulse on ps2Clk with FILTER_LEN=4 produces no strobe and no state change.
- Assert rst=0 mid-frame with 2 codes queued.
  - Next cycle: rdData=0x0000, intReq=0.
  - A fresh valid frame 0x5A after release gives 0x805A.

Source files
------------

// File: rtl/keyboard_ctrl_pkg.sv
// Shared definitions for the PS/2 keyboard controller: frame states,
// status-word bit positions and the odd-parity check.
package keyboard_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } frame_state_t;

   localparam int VALID_BIT   = 15;
   localparam int OVF_BIT     = 14;
   localparam int PAR_BIT     = 13;
   localparam int FRM_BIT     = 12;
   localparam int DEF_TIMEOUT = 50000;

   function automatic logic odd_parity_ok(input logic [7:0] code, input logic par);
      return ^{code, par};
   endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous scancode FIFO; a push into a full FIFO is only accepted
// when a pop frees a slot in the same cycle.
module kbd_fifo
   import keyboard_ctrl_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Storage array, written on accepted pushes.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/keyboard_ctrl.sv
// PS/2 keyboard receiver: conditions the raw lines, decodes frames into a
// scancode FIFO, keeps sticky error flags and raises a vectored interrupt.
module keyboard_ctrl
   import keyboard_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int FILTER_LEN = 4,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2Clk,
   input  logic        ps2Data,
   input  logic        en,
   input  logic [31:0] vecAddr,
   output logic        intReq,
   output logic [31:0] intAddr,
   input  logic        intAck,
   input  logic        pop,
   input  logic        errClr,
   output logic [15:0] rdData
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          clk_filt;
   logic [FW-1:0] filt_cnt;
   logic          strobe;
   logic          sample;

   frame_state_t  state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_bit;
   logic [TW-1:0] tcnt;
   logic          push_req;
   logic [7:0]    push_code;
   logic          par_set;
   logic          frm_set;

   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_head;
   logic          ovf_set;
   logic          ovf_err;
   logic          par_err;
   logic          frm_err;
   logic          int_block;

   // Synchronise both lines, debounce the clock and strobe on its falling edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_filt  <= 1'b1;
         filt_cnt  <= '0;
         strobe    <= 1'b0;
         sample    <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2Clk};
         data_sync <= {data_sync[0], ps2Data};
         strobe    <= 1'b0;
         if (clk_sync[1] == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_sync[1];
            filt_cnt <= '0;
            strobe   <= clk_filt;
            sample   <= data_sync[1];
         end else begin
            filt_cnt <= filt_cnt + FW'(1);
         end
      end
   end

   // Frame decoder with inactivity timeout; completed bytes push one cycle later.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         bit_cnt   <= 3'd0;
         shreg     <= 8'h00;
         par_bit   <= 1'b0;
         tcnt      <= '0;
         push_req  <= 1'b0;
         push_code <= 8'h00;
         par_set   <= 1'b0;
         frm_set   <= 1'b0;
      end else begin
         push_req <= 1'b0;
         par_set  <= 1'b0;
         frm_set  <= 1'b0;
         if (strobe || state == IDLE) begin
            tcnt <= '0;
         end else begin
            tcnt <= tcnt + TW'(1);
         end
         if (!strobe && state != IDLE && tcnt == TW'(TIMEOUT - 1)) begin
            state   <= IDLE;
            frm_set <= 1'b1;
         end else if (strobe) begin
            case (state)
               IDLE: begin
                  if (!sample) begin
                     state   <= DATA;
                     bit_cnt <= 3'd0;
                  end
               end
               DATA: begin
                  shreg   <= {sample, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state <= PARITY;
                  end
               end
               PARITY: begin
                  par_bit <= sample;
                  state   <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (!sample) begin
                     frm_set <= 1'b1;
                  end
                  if (!odd_parity_ok(shreg, par_bit)) begin
                     par_set <= 1'b1;
                  end
                  if (sample && odd_parity_ok(shreg, par_bit)) begin
                     push_req  <= 1'b1;
                     push_code <= shreg;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   kbd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .din   (push_code),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   assign ovf_set = push_req && fifo_full && !pop;

   // Sticky error flags; a new error in the clearing cycle keeps its flag set.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ovf_err <= 1'b0;
         par_err <= 1'b0;
         frm_err <= 1'b0;
      end else begin
         ovf_err <= ovf_set | (ovf_err & ~errClr);
         par_err <= par_set | (par_err & ~errClr);
         frm_err <= frm_set | (frm_err & ~errClr);
      end
   end

   // Level interrupt; int_block suppresses re-assertion for one cycle after an ack.
   always_ff @(posedge clk) begin
      if (!rst) begin
         intReq    <= 1'b0;
         intAddr   <= 32'h0000_0000;
         int_block <= 1'b0;
      end else if (intReq) begin
         if (intAck) begin
            intReq    <= 1'b0;
            int_block <= 1'b1;
         end
      end else begin
         int_block <= 1'b0;
         if (!int_block && en && !fifo_empty && !intAck) begin
            intReq  <= 1'b1;
            intAddr <= vecAddr;
         end
      end
   end

   // Status/data word seen by the CPU.
   always_comb begin
      rdData            = 16'h0000;
      rdData[VALID_BIT] = !fifo_empty;
      rdData[OVF_BIT]   = ovf_err;
      rdData[PAR_BIT]   = par_err;
      rdData[FRM_BIT]   = frm_err;
      if (fifo_empty) begin
         rdData[7:0] = 8'h00;
      end else begin
         rdData[7:0] = fifo_head;
      end
   end

endmodule

// File: tb/tb_keyboard_ctrl.sv
// Bench for keyboard_ctrl: directed sequences, a vector table and a random
// phase scored against a queue-based model of the FIFO and sticky flags.
module tb_keyboard_ctrl;

   localparam int DEPTH    = 8;
   localparam int FILT     = 4;
   localparam int TMO      = 300;
   localparam int HALF     = 10;

   localparam logic [1:0] OP_FRAME = 2'd0;
   localparam logic [1:0] OP_POP   = 2'd1;
   localparam logic [1:0] OP_CLR   = 2'd2;

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  code;
      logic        flip;
      logic        stop;
      logic [15:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ps2Clk;
   logic        ps2Data;
   logic        en;
   logic [31:0] vecAddr;
   logic        intReq;
   logic [31:0] intAddr;
   logic        intAck;
   logic        pop;
   logic        errClr;
   logic [15:0] rdData;

   int checks = 0;
   int passes = 0;

   logic [7:0] mq[$];
   logic       mo, mp, mf;
   vec_t       tbl[$];

   keyboard_ctrl #(
      .FIFO_DEPTH (DEPTH),
      .FILTER_LEN (FILT),
      .TIMEOUT    (TMO)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .ps2Clk  (ps2Clk),
      .ps2Data (ps2Data),
      .en      (en),
      .vecAddr (vecAddr),
      .intReq  (intReq),
      .intAddr (intAddr),
      .intAck  (intAck),
      .pop     (pop),
      .errClr  (errClr),
      .rdData  (rdData)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      ps2Data = b;
      repeat (HALF) @(negedge clk);
      ps2Clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2Clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] code, input logic flip, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(code[i]);
      send_bit(~(^code) ^ flip);
      send_bit(stop);
      repeat (HALF) @(negedge clk);
      ps2Data = 1'b1;
   endtask

   task automatic pulse_pop();
      pop = 1'b1;
      @(negedge clk);
      pop = 1'b0;
   endtask

   task automatic pulse_clr();
      errClr = 1'b1;
      @(negedge clk);
      errClr = 1'b0;
   endtask

   function automatic vec_t mk(input logic [1:0] op, input logic [7:0] code,
                               input logic flip, input logic stop, input logic [15:0] exp);
      vec_t v;
      v.op = op; v.code = code; v.flip = flip; v.stop = stop; v.exp = exp;
      return v;
   endfunction

   function automatic logic [15:0] model_rd();
      logic ne;
      ne = (mq.size() != 0);
      return {ne, mo, mp, mf, 4'b0000, ne ? mq[0] : 8'h00};
   endfunction

   initial begin
      rst = 1'b0; ps2Clk = 1'b1; ps2Data = 1'b1; en = 1'b0; vecAddr = 32'h0;
      intAck = 1'b0; pop = 1'b0; errClr = 1'b0;
      repeat (4) @(negedge clk);
      check("reset_rd", {16'h0, rdData}, 32'h0000);
      check("reset_int", {31'h0, intReq}, 32'h0);
      check("reset_addr", intAddr, 32'h0);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      // valid frame, interrupt latch, hold, ack, re-arm
      en = 1'b1; vecAddr = 32'h0000_1234;
      send_frame(8'h1C, 1'b0, 1'b1);
      check("f1c_rd", {16'h0, rdData}, 32'h801C);
      check("f1c_int", {31'h0, intReq}, 32'h1);
      check("f1c_addr", intAddr, 32'h0000_1234);
      vecAddr = 32'h0000_DEAD;
      @(negedge clk);
      check("addr_hold", intAddr, 32'h0000_1234);
      intAck = 1'b1;
      @(negedge clk);
      intAck = 1'b0;
      check("ack_clear", {31'h0, intReq}, 32'h0);
      @(negedge clk);
      check("rearm_block", {31'h0, intReq}, 32'h0);
      @(negedge clk);
      check("rearm_int", {31'h0, intReq}, 32'h1);
      check("rearm_addr", intAddr, 32'h0000_DEAD);
      en = 1'b0;
      @(negedge clk);
      check("en_drop_hold", {31'h0, intReq}, 32'h1);
      intAck = 1'b1;
      @(negedge clk);
      intAck = 1'b0;
      pulse_pop();
      check("pop_rd", {16'h0, rdData}, 32'h0000);
      check("pop_int", {31'h0, intReq}, 32'h0);

      // bad parity with interrupts enabled
      en = 1'b1;
      send_frame(8'h1C, 1'b1, 1'b1);
      check("par_rd", {16'h0, rdData}, 32'h2000);
      check("par_int", {31'h0, intReq}, 32'h0);
      en = 1'b0;

      tbl.push_back(mk(OP_CLR, 8'h00, 1'b0, 1'b1, 16'h0000));
      for (int k = 1; k <= 8; k++) tbl.push_back(mk(OP_FRAME, 8'(k), 1'b0, 1'b1, 16'h8001));
      tbl.push_back(mk(OP_FRAME, 8'h09, 1'b0, 1'b1, 16'hC001));
      for (int k = 2; k <= 8; k++) tbl.push_back(mk(OP_POP, 8'h00, 1'b0, 1'b1, 16'hC000 | 16'(k)));
      tbl.push_back(mk(OP_POP,   8'h00, 1'b0, 1'b1, 16'h4000));
      tbl.push_back(mk(OP_CLR,   8'h00, 1'b0, 1'b1, 16'h0000));
      tbl.push_back(mk(OP_FRAME, 8'h55, 1'b0, 1'b0, 16'h1000));
      tbl.push_back(mk(OP_CLR,   8'h00, 1'b0, 1'b1, 16'h0000));
      tbl.push_back(mk(OP_POP,   8'h00, 1'b0, 1'b1, 16'h0000));
      tbl.push_back(mk(OP_FRAME, 8'hA5, 1'b0, 1'b1, 16'h80A5));
      tbl.push_back(mk(OP_FRAME, 8'h3C, 1'b1, 1'b0, 16'hB0A5));
      tbl.push_back(mk(OP_POP,   8'h00, 1'b0, 1'b1, 16'h3000));
      tbl.push_back(mk(OP_CLR,   8'h00, 1'b0, 1'b1, 16'h0000));
      foreach (tbl[i]) begin
         case (tbl[i].op)
            OP_FRAME: send_frame(tbl[i].code, tbl[i].flip, tbl[i].stop);
            OP_POP:   pulse_pop();
            default:  pulse_clr();
         endcase
         check($sformatf("tbl%0d", i), {16'h0, rdData}, {16'h0, tbl[i].exp});
      end

      // timeout after 4 data bits
      send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      ps2Data = 1'b1;
      repeat (TMO / 2) @(negedge clk);
      check("tmo_early", {16'h0, rdData}, 32'h0000);
      repeat (TMO - TMO / 2 + 2) @(negedge clk);
      check("tmo_frm", {16'h0, rdData}, 32'h1000);
      send_frame(8'hF0, 1'b0, 1'b1);
      check("tmo_next", {16'h0, rdData}, 32'h90F0);
      pulse_pop();
      pulse_clr();
      check("tmo_clean", {16'h0, rdData}, 32'h0000);

      // 2-cycle glitch with data low must not look like a start bit
      ps2Data = 1'b0;
      ps2Clk = 1'b0;
      repeat (2) @(negedge clk);
      ps2Clk = 1'b1;
      repeat (HALF) @(negedge clk);
      ps2Data = 1'b1;
      repeat (HALF) @(negedge clk);
      send_frame(8'h3A, 1'b0, 1'b1);
      check("glitch", {16'h0, rdData}, 32'h803A);
      pulse_pop();

      // reset mid-frame with two codes queued
      en = 1'b1; vecAddr = 32'h0000_0BEE;
      send_frame(8'h11, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1);
      check("pre_rst_rd", {16'h0, rdData}, 32'h8011);
      check("pre_rst_int", {31'h0, intReq}, 32'h1);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      ps2Clk = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("rst_rd", {16'h0, rdData}, 32'h0000);
      check("rst_int", {31'h0, intReq}, 32'h0);
      check("rst_addr", intAddr, 32'h0);
      ps2Clk = 1'b1; ps2Data = 1'b1; en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (HALF) @(negedge clk);
      send_frame(8'h5A, 1'b0, 1'b1);
      check("post_rst", {16'h0, rdData}, 32'h805A);
      pulse_pop();

      // random phase against the model
      mo = 1'b0; mp = 1'b0; mf = 1'b0;
      for (int it = 0; it < 50; it++) begin
         int r;
         logic [7:0] code;
         logic flip, stop;
         r = $urandom_range(0, 9);
         if (r < 6) begin
            code = 8'($urandom);
            flip = ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 7) != 0);
            send_frame(code, flip, stop);
            if (!stop) mf = 1'b1;
            if (flip) mp = 1'b1;
            if (!flip && stop) begin
               if (mq.size() == DEPTH) mo = 1'b1;
               else mq.push_back(code);
            end
         end else if (r < 9) begin
            pulse_pop();
            if (mq.size() != 0) void'(mq.pop_front());
         end else begin
            pulse_clr();
            mo = 1'b0; mp = 1'b0; mf = 1'b0;
         end
         check($sformatf("rand%0d", it), {16'h0, rdData}, {16'h0, model_rd()});
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
